mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_ctrl_pkg.sv | 52 +++++
 rtl/mc_alu_decoder.sv | 38 +++
 rtl/mc_control_unit.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multi-cycle control unit.
//   state_t       FSM states (MDUWAIT only when CTRL_MDU_EN is defined)
//   result_src_t  Result bus select
//   alu_src_a_t   ALU operand A select
//   alu_src_b_t   ALU operand B select
//   adr_src_t     memory address select
//   alu_op_t      ALU operation encoding
//   trap_cause_t  trap cause encoding
//   alu_mode_t    control-to-ALU-decoder mode
// Optional feature macro: CTRL_MDU_EN.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXER, EXEI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
`ifdef CTRL_MDU_EN
        , MDUWAIT
`endif
    } state_t;

    typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALURESULT, RES_MDU} result_src_t;
    typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1, SRCA_ZERO}    alu_src_a_t;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR}               alu_src_b_t;
    typedef enum logic       {ADR_PC, ADR_RESULT}                          adr_src_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef enum logic [1:0] {TC_NONE, TC_ILLEGAL, TC_BUS, TC_MDU} trap_cause_t;

    // AM_FUNCT lets funct3/funct7_5 pick the operation
    typedef enum logic [1:0] {AM_ADD, AM_SUB, AM_FUNCT} alu_mode_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational ALU operation decode.
//   i_mode      AM_ADD / AM_SUB force the operation, AM_FUNCT decodes funct fields
//   i_is_op     1 for register-register (OP), 0 for OP-IMM
//   i_funct3    instruction funct3
//   i_funct7_5  instruction bit 30 (SUB/SRA selector)
//   o_op        decoded ALU operation
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_mode_t   i_mode,
    input  logic        i_is_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    output alu_op_t     o_op
);

    always_comb begin
        o_op = ALU_ADD;
        case (i_mode)
            AM_SUB:   o_op = ALU_SUB;
            AM_FUNCT: begin
                case (i_funct3)
                    // bit 30 is part of the immediate for addi, so only OP may select SUB
                    3'b000:  o_op = (i_is_op && i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_op = ALU_SLL;
                    3'b010:  o_op = ALU_SLT;
                    3'b011:  o_op = ALU_SLTU;
                    3'b100:  o_op = ALU_XOR;
                    3'b101:  o_op = i_funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  o_op = ALU_OR;
                    default: o_op = ALU_AND;
                endcase
            end
            default:  o_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RISC-V control FSM.
//   clk, rst                       clock, synchronous active-high reset
//   opcode/funct3/funct7_5         instruction fields from the IR
//   funct7_0                       IR bit 25, separates funct7=0000001 (M-extension) on OP
//   zeroFlag/ltFlag/ltuFlag        ALU compare flags
//   memReady                       memory completes the current request
//   PCWrite/RegWrite/MemWrite/IRWrite/MemReq   enables
//   ResultSrc/ALUSrcA/ALUSrcB/AdrSrc/ALUControl/immSrc   datapath controls
//   Trap/TrapCause                 sticky trap indication
//   MduStart/MduDone/MduErr        multiply/divide handshake (CTRL_MDU_EN only)
// Optional feature macro: CTRL_MDU_EN.
// Datapath contract for jumps: the PC register already holds OldPC+4 after
// FETCH and is the link value written to rd; JALR's PC input has bit 0 masked.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int MAX_WAIT   = 15
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  funct7_0,
    input  logic                  zeroFlag,
    input  logic                  ltFlag,
    input  logic                  ltuFlag,
    input  logic                  memReady,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  MemReq,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic                  AdrSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [2:0]            immSrc,
    output logic                  Trap,
    output logic [1:0]            TrapCause
`ifdef CTRL_MDU_EN
   ,output logic                  MduStart,
    input  logic                  MduDone,
    input  logic                  MduErr
`endif
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    state_t      r_state, w_next;
    trap_cause_t r_cause, w_cause;
    logic [WAIT_W-1:0] r_wait;
    logic        w_at_lim, w_taken;
    logic        w_pcw, w_rw, w_mw, w_irw, w_mreq;
    result_src_t w_rs;
    alu_src_a_t  w_sa;
    alu_src_b_t  w_sb;
    adr_src_t    w_adr;
    alu_mode_t   w_mode;
    alu_op_t     w_alu;
`ifdef CTRL_MDU_EN
    logic        r_mdu_prev, r_res_mdu, w_mstart;
`endif

    // this stall cycle would be number MAX_WAIT
    assign w_at_lim = (MAX_WAIT != 0) && (int'(r_wait) == MAX_WAIT - 1);

    always_comb begin
        w_next  = r_state;
        w_cause = TC_NONE;
        w_pcw   = 1'b0;
        w_rw    = 1'b0;
        w_mw    = 1'b0;
        w_irw   = 1'b0;
        w_mreq  = 1'b0;
        w_rs    = RES_ALUOUT;
        w_sa    = SRCA_PC;
        w_sb    = SRCB_RS2;
        w_adr   = ADR_PC;
        w_mode  = AM_ADD;
        w_taken = 1'b0;
`ifdef CTRL_MDU_EN
        w_mstart = 1'b0;
`endif
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    w_mreq = 1'b1;
                    // memReady is tested first so it wins over the timeout
                    if (memReady) begin
                        w_irw  = 1'b1;
                        w_pcw  = 1'b1;
                        w_rs   = RES_ALURESULT;
                        w_sb   = SRCB_FOUR;
                        w_next = DECODE;
                    end else if (w_at_lim) begin
                        w_next  = TRAP;
                        w_cause = TC_BUS;
                    end
                end
                DECODE: begin
                    w_sa = SRCA_OLDPC;
                    w_sb = SRCB_IMM;
                    case (opcode)
                        OPC_LOAD, OPC_STORE: w_next = MEMADR;
                        OPC_OP:     w_next = EXER;
                        OPC_OPIMM:  w_next = EXEI;
                        OPC_BRANCH: w_next = BRANCH;
                        OPC_JAL:    w_next = JAL;
                        OPC_JALR:   w_next = JALR;
                        OPC_LUI:    w_next = LUI;
                        OPC_AUIPC:  w_next = AUIPC;
                        default: begin
                            w_next  = TRAP;
                            w_cause = TC_ILLEGAL;
                        end
                    endcase
                end
                MEMADR: begin
                    w_sa   = SRCA_RS1;
                    w_sb   = SRCB_IMM;
                    w_next = (opcode == OPC_STORE) ? MEMWR : MEMRD;
                end
                MEMRD, MEMWR: begin
                    w_mreq = 1'b1;
                    w_mw   = (r_state == MEMWR);
                    w_adr  = ADR_RESULT;
                    if (memReady) begin
                        w_next = (r_state == MEMWR) ? FETCH : MEMWB;
                    end else if (w_at_lim) begin
                        w_next  = TRAP;
                        w_cause = TC_BUS;
                    end
                end
                MEMWB: begin
                    w_rw   = 1'b1;
                    w_rs   = RES_DATA;
                    w_next = FETCH;
                end
                EXER: begin
                    w_sa   = SRCA_RS1;
                    w_sb   = SRCB_RS2;
                    w_mode = AM_FUNCT;
                    if (funct7_0 && !funct7_5) begin
`ifdef CTRL_MDU_EN
                        w_next = MDUWAIT;
`else
                        w_next  = TRAP;
                        w_cause = TC_ILLEGAL;
`endif
                    end else begin
                        w_next = ALUWB;
                    end
                end
                EXEI: begin
                    w_sa   = SRCA_RS1;
                    w_sb   = SRCB_IMM;
                    w_mode = AM_FUNCT;
                    w_next = ALUWB;
                end
                ALUWB: begin
                    w_rw   = 1'b1;
`ifdef CTRL_MDU_EN
                    w_rs   = r_res_mdu ? RES_MDU : RES_ALUOUT;
`endif
                    w_next = FETCH;
                end
                BRANCH: begin
                    w_sa   = SRCA_RS1;
                    w_sb   = SRCB_RS2;
                    w_mode = AM_SUB;
                    w_next = FETCH;
                    case (funct3)
                        3'b000:  w_taken = zeroFlag;
                        3'b001:  w_taken = !zeroFlag;
                        3'b100:  w_taken = ltFlag;
                        3'b101:  w_taken = !ltFlag;
                        3'b110:  w_taken = ltuFlag;
                        3'b111:  w_taken = !ltuFlag;
                        default: begin
                            w_next  = TRAP;
                            w_cause = TC_ILLEGAL;
                        end
                    endcase
                    w_pcw = w_taken;
                end
                JAL: begin
                    // target was left in ALUOut by DECODE
                    w_sa   = SRCA_OLDPC;
                    w_sb   = SRCB_FOUR;
                    w_rw   = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = FETCH;
                end
                JALR: begin
                    w_sa   = SRCA_RS1;
                    w_sb   = SRCB_IMM;
                    w_rs   = RES_ALURESULT;
                    w_rw   = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = FETCH;
                end
                LUI: begin
                    w_sa   = SRCA_ZERO;
                    w_sb   = SRCB_IMM;
                    w_rs   = RES_ALURESULT;
                    w_rw   = 1'b1;
                    w_next = FETCH;
                end
                AUIPC: begin
                    // OldPC+imm is already in ALUOut
                    w_rw   = 1'b1;
                    w_next = FETCH;
                end
`ifdef CTRL_MDU_EN
                MDUWAIT: begin
                    w_mstart = !r_mdu_prev;
                    if (MduErr) begin
                        w_next  = TRAP;
                        w_cause = TC_MDU;
                    end else if (MduDone) begin
                        w_next = ALUWB;
                    end
                end
`endif
                TRAP:    w_next = TRAP;
                default: w_next = FETCH;
            endcase
        end
    end

    mc_alu_decoder u_alu_dec (
        .i_mode     (w_mode),
        .i_is_op    (opcode == OPC_OP),
        .i_funct3   (funct3),
        .i_funct7_5 (funct7_5),
        .o_op       (w_alu)
    );

    always_comb begin
        case (opcode)
            OPC_STORE:          immSrc = IMM_S;
            OPC_BRANCH:         immSrc = IMM_B;
            OPC_JAL:            immSrc = IMM_J;
            OPC_LUI, OPC_AUIPC: immSrc = IMM_U;
            default:            immSrc = IMM_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_cause <= TC_NONE;
            r_wait  <= '0;
`ifdef CTRL_MDU_EN
            r_mdu_prev <= 1'b0;
            r_res_mdu  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_next == TRAP && r_state != TRAP)
                r_cause <= w_cause;
            if (memReady || w_next != r_state)
                r_wait <= '0;
            else if (w_mreq && r_wait != '1)
                r_wait <= r_wait + 1'b1;
`ifdef CTRL_MDU_EN
            r_mdu_prev <= (r_state == MDUWAIT);
            if (r_state == MDUWAIT && w_next == ALUWB)
                r_res_mdu <= 1'b1;
            else if (r_state == ALUWB)
                r_res_mdu <= 1'b0;
`endif
        end
    end

    assign PCWrite    = w_pcw;
    assign RegWrite   = w_rw;
    assign MemWrite   = w_mw;
    assign IRWrite    = w_irw;
    assign MemReq     = w_mreq;
    assign ResultSrc  = w_rs;
    assign ALUSrcA    = w_sa;
    assign ALUSrcB    = w_sb;
    assign AdrSrc     = w_adr;
    assign ALUControl = ALU_CTRL_W'(w_alu);
    assign Trap       = !rst && (r_state == TRAP);
    assign TrapCause  = rst ? 2'b00 : r_cause;
`ifdef CTRL_MDU_EN
    assign MduStart   = w_mstart;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for mc_control_unit (MAX_WAIT=4).
// Each cycle record carries the stimulus and the expected outputs; a task
// queues the records for its scenario, then pops and compares one per cycle.
module tb_mc_control_unit;

    typedef struct packed {
        logic       pcw, rw, mw, irw, mq;
        logic [1:0] rs, sa, sb;
        logic       adr;
        logic [3:0] alu;
        logic       tr;
        logic [1:0] c;
        logic       ms;
    } ov_t;

    typedef struct packed {
        logic       r, rdy;
        logic [2:0] fl;   // {zero, lt, ltu}
        logic [1:0] md;   // {done, err}
        ov_t        e;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, funct7_0 = 1'b0;
    logic       zeroFlag = 1'b0, ltFlag = 1'b0, ltuFlag = 1'b0, memReady = 1'b0;
    logic       PCWrite, RegWrite, MemWrite, IRWrite, MemReq, AdrSrc, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, TrapCause;
    logic [3:0] ALUControl;
    logic [2:0] immSrc;
`ifdef CTRL_MDU_EN
    logic       MduStart, MduDone = 1'b0, MduErr = 1'b0;
`endif

    int   total = 0;
    int   bad   = 0;
    cyc_t sb[$];
    ov_t  Z;

    always #5 clk = ~clk;

    mc_control_unit #(.ALU_CTRL_W(4), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .funct7_0(funct7_0),
        .zeroFlag(zeroFlag), .ltFlag(ltFlag), .ltuFlag(ltuFlag), .memReady(memReady),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemReq(MemReq), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .AdrSrc(AdrSrc), .ALUControl(ALUControl), .immSrc(immSrc),
        .Trap(Trap), .TrapCause(TrapCause)
`ifdef CTRL_MDU_EN
       ,.MduStart(MduStart), .MduDone(MduDone), .MduErr(MduErr)
`endif
    );

    function automatic ov_t mk(logic pcw, logic rw, logic mw, logic irw, logic mq,
                               logic [1:0] rs, logic [1:0] sa, logic [1:0] sbv, logic adr,
                               logic [3:0] alu, logic tr, logic [1:0] c, logic ms = 1'b0);
        ov_t o;
        o.pcw = pcw; o.rw = rw; o.mw = mw; o.irw = irw; o.mq = mq;
        o.rs = rs; o.sa = sa; o.sb = sbv; o.adr = adr; o.alu = alu;
        o.tr = tr; o.c = c; o.ms = ms;
        return o;
    endfunction

    function automatic cyc_t cy(logic r, logic rdy, logic [2:0] fl, logic [1:0] md, ov_t e);
        cyc_t k;
        k.r = r; k.rdy = rdy; k.fl = fl; k.md = md; k.e = e;
        return k;
    endfunction

    function automatic ov_t obs();
        ov_t o;
        o = mk(PCWrite, RegWrite, MemWrite, IRWrite, MemReq, ResultSrc, ALUSrcA, ALUSrcB,
               AdrSrc, ALUControl, Trap, TrapCause);
`ifdef CTRL_MDU_EN
        o.ms = MduStart;
`endif
        return o;
    endfunction

    task automatic set_instr(logic [6:0] opc, logic [2:0] f3, logic f75, logic f70);
        opcode = opc; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    endtask

    task automatic apply(cyc_t k);
        rst = k.r; memReady = k.rdy;
        {zeroFlag, ltFlag, ltuFlag} = k.fl;
`ifdef CTRL_MDU_EN
        {MduDone, MduErr} = k.md;
`endif
    endtask

    // common expectations
    function automatic ov_t e_fetch_rdy(); return mk(1,0,0,1,1, 2,0,2, 0, 0, 0,0); endfunction
    function automatic ov_t e_stall();     return mk(0,0,0,0,1, 0,0,0, 0, 0, 0,0); endfunction
    function automatic ov_t e_decode();    return mk(0,0,0,0,0, 0,1,1, 0, 0, 0,0); endfunction

    task automatic test_reset();
        int n = 0;
        cyc_t k;
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(1, 1, 3'b111, 2'b00, Z));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL reset cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_add();
        int n = 0;
        cyc_t k;
        set_instr(7'h33, 3'b000, 1'b0, 1'b0);
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,1,0,0,0, 0,0,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, e_stall()));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL add cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_alu_ops();
        logic [6:0] opcs [4] = '{7'h33, 7'h13, 7'h13, 7'h33};
        logic [2:0] f3s  [4] = '{3'b000, 3'b101, 3'b000, 3'b111};
        logic       f75s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] alus [4] = '{4'd1, 4'd9, 4'd0, 4'd2};   // sub, srai, addi, and
        int n = 0;
        cyc_t k;
        for (int i = 0; i < 4; i++) begin
            set_instr(opcs[i], f3s[i], f75s[i], 1'b0);
            sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
            sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
            sb.push_back(cy(0, 1, 3'b000, 2'b00,
                mk(0,0,0,0,0, 0,2,(opcs[i] == 7'h13) ? 2'd1 : 2'd0, 0, alus[i], 0,0)));
            sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,1,0,0,0, 0,0,0, 0, 0, 0,0)));
            while (sb.size() != 0) begin
                k = sb.pop_front(); apply(k); @(negedge clk); total++;
                if (obs() !== k.e) begin bad++; $display("FAIL aluop%0d cyc%0d got=%h want=%h", i, n, obs(), k.e); end
                @(posedge clk); #1; n++;
            end
        end
    endtask

    task automatic test_lw_stall();
        int n = 0;
        cyc_t k;
        set_instr(7'h03, 3'b010, 1'b0, 1'b0);
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,1, 0, 0, 0,0)));
        for (int i = 0; i < 3; i++)
            sb.push_back(cy(0, 0, 3'b000, 2'b00, mk(0,0,0,0,1, 0,0,0, 1, 0, 0,0)));
        // memReady arrives with the counter one short of the limit
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,1, 0,0,0, 1, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, mk(0,1,0,0,0, 1,0,0, 0, 0, 0,0)));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL lw cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [3] = '{3'b101, 3'b101, 3'b110};   // bge, bge, bltu
        logic [2:0] fls [3] = '{3'b000, 3'b010, 3'b001};
        logic       tk  [3] = '{1'b1, 1'b0, 1'b1};
        int n = 0;
        cyc_t k;
        for (int i = 0; i < 3; i++) begin
            set_instr(7'h63, f3s[i], 1'b0, 1'b0);
            sb.push_back(cy(0, 1, fls[i], 2'b00, e_fetch_rdy()));
            sb.push_back(cy(0, 1, fls[i], 2'b00, e_decode()));
            sb.push_back(cy(0, 1, fls[i], 2'b00, mk(tk[i],0,0,0,0, 0,2,0, 0, 1, 0,0)));
            while (sb.size() != 0) begin
                k = sb.pop_front(); apply(k); @(negedge clk); total++;
                if (obs() !== k.e) begin bad++; $display("FAIL branch%0d cyc%0d got=%h want=%h", i, n, obs(), k.e); end
                @(posedge clk); #1; n++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        cyc_t k;
        set_instr(7'h23, 3'b010, 1'b0, 1'b0);
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,1, 0, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, mk(0,0,1,0,1, 0,0,0, 1, 0, 0,0)));
        sb.push_back(cy(1, 1, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, e_stall()));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL rstmid cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_illegal();
        int n = 0;
        cyc_t k;
        ov_t t1;
        t1 = mk(0,0,0,0,0, 0,0,0, 0, 0, 1,1);
        set_instr(7'h7F, 3'b000, 1'b0, 1'b0);
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, t1));
        sb.push_back(cy(0, 1, 3'b111, 2'b00, t1));
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, e_stall()));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL illegal cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
        // branch with funct3=010
        set_instr(7'h63, 3'b010, 1'b0, 1'b0);
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 1, 3'b111, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b111, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b111, 2'b00, mk(0,0,0,0,0, 0,2,0, 0, 1, 0,0)));
        sb.push_back(cy(0, 1, 3'b111, 2'b00, t1));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL badbr cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
`ifndef CTRL_MDU_EN
        // mul without the MDU option
        set_instr(7'h33, 3'b000, 1'b0, 1'b1);
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, t1));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL nomdu cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
`endif
    endtask

    task automatic test_timeout();
        int n = 0;
        cyc_t k;
        ov_t t2;
        t2 = mk(0,0,0,0,0, 0,0,0, 0, 0, 1,2);
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        for (int i = 0; i < 4; i++)
            sb.push_back(cy(0, 0, 3'b000, 2'b00, e_stall()));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, t2));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, t2));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, t2));
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL timeout cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask

`ifdef CTRL_MDU_EN
    task automatic test_mdu();
        int n = 0;
        cyc_t k;
        set_instr(7'h33, 3'b000, 1'b0, 1'b1);
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, mk(0,0,0,0,0, 0,0,0, 0, 0, 0,0, 1)));
        for (int i = 0; i < 3; i++)
            sb.push_back(cy(0, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 0, 3'b000, 2'b10, Z));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, mk(0,1,0,0,0, 3,0,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b00, e_stall()));
        // error path
        sb.push_back(cy(1, 0, 3'b000, 2'b00, Z));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_fetch_rdy()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, e_decode()));
        sb.push_back(cy(0, 1, 3'b000, 2'b00, mk(0,0,0,0,0, 0,2,0, 0, 0, 0,0)));
        sb.push_back(cy(0, 0, 3'b000, 2'b01, mk(0,0,0,0,0, 0,0,0, 0, 0, 0,0, 1)));
        sb.push_back(cy(0, 0, 3'b000, 2'b10, mk(0,0,0,0,0, 0,0,0, 0, 0, 1,3)));
        while (sb.size() != 0) begin
            k = sb.pop_front(); apply(k); @(negedge clk); total++;
            if (obs() !== k.e) begin bad++; $display("FAIL mdu cyc%0d got=%h want=%h", n, obs(), k.e); end
            @(posedge clk); #1; n++;
        end
    endtask
`endif

    initial begin
        Z = '0;
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_stall();
        test_branch();
        test_reset_mid();
        test_illegal();
        test_timeout();
`ifdef CTRL_MDU_EN
        test_mdu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
